ifft_output_streamer: RTL and testbench

- Downstream stage of the IFFT core. It drains the 4096-point result RAM after a transform completes and streams the real part of each bin as a 12-bit offset-binary DAC/audio sample.
- It owns the result-RAM read port during streaming. It buffers samples in a small FIFO so that RAM read latency is decoupled from the sample-rate strobe.
- Each result word is 32 bits: real part in bits [31:16], imaginary part in bits [15:0], both signed 16-bit. The imaginary part is discarded.

---
 rtl/ifft_output_streamer.sv | 155 +++++++++++++++
 tb/tb_ifft_output_streamer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifft_output_streamer.sv
// Drains the IFFT result RAM after each completed transform and streams the real part
// of every bin as a saturated 12-bit offset-binary sample, paced by sample_tick.
module ifft_output_streamer #(
    parameter int N          = 4096,
    parameter int ADDR_W     = 12,
    parameter int SHIFT      = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              frame_valid,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [31:0]       ram_q,
    input  logic              sample_tick,
    output logic [11:0]       dac_sample,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(N - 1);
    localparam logic [CNT_W:0]    DEPTH_CREDIT = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    state_t state, state_next;

    logic [11:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic              inflight;

    logic [ADDR_W-1:0] addr_next;
    logic              busy_next, done_next, issue, accept;
    logic              push, pop, fifo_empty;
    logic [CNT_W:0]    credit;

    logic signed [15:0] real_part, shifted;
    logic [11:0]        sat, sample_in;

    // Data read last cycle is on ram_q now; scale, clamp and convert to offset binary.
    always_comb begin
        real_part = $signed(ram_q[31:16]);
        shifted   = real_part >>> SHIFT;
        if (shifted > 16'sd2047) begin
            sat = 12'h7FF;
        end else if (shifted < -16'sd2048) begin
            sat = 12'h800;
        end else begin
            sat = shifted[11:0];
        end
        sample_in = {~sat[11], sat[10:0]};
    end

    assign fifo_empty = (fifo_count == '0);
    assign push       = inflight;
    assign pop        = sample_tick && !fifo_empty;
    // Reads in flight are counted as occupied slots so the FIFO can never overflow.
    assign credit     = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};

    always_comb begin
        state_next = state;
        addr_next  = ram_addr;
        busy_next  = busy;
        done_next  = 1'b0;
        issue      = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (frame_valid) begin
                    accept     = 1'b1;
                    state_next = READ;
                    addr_next  = '0;
                    busy_next  = 1'b1;
                end
            end
            READ: begin
                if (credit < DEPTH_CREDIT) begin
                    issue = 1'b1;
                    if (ram_addr == LAST_ADDR) begin
                        state_next = DRAIN;
                    end else begin
                        addr_next = ram_addr + ADDR_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (pop && !inflight && fifo_count == CNT_W'(1)) begin
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            ram_addr   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            inflight   <= 1'b0;
        end else begin
            state      <= state_next;
            ram_addr   <= addr_next;
            busy       <= busy_next;
            frame_done <= done_next;
            inflight   <= issue;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= sample_in;
        end
    end

    // No bypass: a tick against an empty FIFO is an underrun even if a push lands now.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            dac_sample <= 12'h800;
            underrun   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                dac_sample <= fifo_mem[rd_ptr];
                rd_ptr     <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end
            if (accept) begin
                underrun <= 1'b0;
            end else if (sample_tick && fifo_empty && busy) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ifft_output_streamer.sv
// Scoreboard bench: one full-size streamer (SHIFT=4) and one tiny streamer (N=4, SHIFT=0,
// FIFO_DEPTH=2), each fed by a 1-cycle-latency RAM model.
module tb_ifft_output_streamer;

    localparam int TICK_GAP = 10;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        rst_a, fv_a, tick_a, busy_a, done_a, urun_a;
    logic [11:0] addr_a, dac_a;
    logic [31:0] q_a;

    logic        rst_b, fv_b, tick_b, busy_b, done_b, urun_b;
    logic [1:0]  addr_b;
    logic [11:0] dac_b;
    logic [31:0] q_b;

    int n_compared   = 0;
    int n_mismatched = 0;

    int mode_a = 0;
    logic [11:0] sb_a[$];
    logic [11:0] sb_b[$];

    bit mon_a = 1'b0;
    int last_addr, addr_err, max_occ, pops_a, done_pulses;

    ifft_output_streamer #(.N(4096), .ADDR_W(12), .SHIFT(4), .FIFO_DEPTH(8)) dut_a (
        .CLK(CLK), .RESET(rst_a), .frame_valid(fv_a), .ram_addr(addr_a), .ram_q(q_a),
        .sample_tick(tick_a), .dac_sample(dac_a), .busy(busy_a), .frame_done(done_a),
        .underrun(urun_a)
    );

    ifft_output_streamer #(.N(4), .ADDR_W(2), .SHIFT(0), .FIFO_DEPTH(2)) dut_b (
        .CLK(CLK), .RESET(rst_b), .frame_valid(fv_b), .ram_addr(addr_b), .ram_q(q_b),
        .sample_tick(tick_b), .dac_sample(dac_b), .busy(busy_b), .frame_done(done_b),
        .underrun(urun_b)
    );

    function automatic logic [31:0] word_a(input logic [11:0] a, input int mode);
        if (mode == 1) return {4'h0, a, 16'h0000};
        case (a)
            12'd0:   return 32'h7FFF0000;
            12'd1:   return 32'h80000000;
            12'd2:   return 32'h00100000;
            12'd3:   return 32'hFFF0ABCD;
            default: return 32'h00000000;
        endcase
    endfunction

    function automatic logic [31:0] word_b(input logic [1:0] a);
        case (a)
            2'd0:    return 32'h12340000;
            2'd1:    return 32'hC0000000;
            2'd2:    return 32'h00050000;
            default: return 32'hFFFB0000;
        endcase
    endfunction

    function automatic logic [11:0] ref_sample(input logic [31:0] w, input int sh);
        int r;
        r = int'($signed(w[31:16]));
        r = r >>> sh;
        if (r > 2047) r = 2047;
        if (r < -2048) r = -2048;
        return 12'(r + 2048);
    endfunction

    always @(posedge CLK) begin
        q_a <= word_a(addr_a, mode_a);
        q_b <= word_b(addr_b);
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        @(negedge CLK);
        if (mon_a) begin
            if (int'(addr_a) != last_addr) begin
                if (int'(addr_a) != last_addr + 1) addr_err++;
                last_addr = int'(addr_a);
            end
            if (int'(addr_a) - pops_a > max_occ) max_occ = int'(addr_a) - pops_a;
            if (done_a) done_pulses++;
        end
    endtask

    task automatic applyStimulus(input bit on_b, input int mode);
        if (!on_b) begin
            mode_a = mode;
            sb_a.delete();
            for (int i = 0; i < 4096; i++) sb_a.push_back(ref_sample(word_a(12'(i), mode), 4));
            fv_a = 1'b1;
            cycle();
            fv_a = 1'b0;
        end else begin
            sb_b.delete();
            for (int i = 0; i < 4; i++) sb_b.push_back(ref_sample(word_b(2'(i)), 0));
            fv_b = 1'b1;
            cycle();
            fv_b = 1'b0;
        end
    endtask

    task automatic tickA(input string tag);
        tick_a = 1'b1;
        pops_a++;
        cycle();
        tick_a = 1'b0;
        if (sb_a.size() == 0) checkOutput({tag, "_sb_depth"}, sb_a.size(), 1);
        else checkOutput(tag, dac_a, sb_a.pop_front());
    endtask

    task automatic tickB(input string tag);
        tick_b = 1'b1;
        cycle();
        tick_b = 1'b0;
        if (sb_b.size() == 0) checkOutput({tag, "_sb_depth"}, sb_b.size(), 1);
        else checkOutput(tag, dac_b, sb_b.pop_front());
    endtask

    task automatic drainB();
        for (int i = 0; i < 4; i++) begin
            tickB("b_data");
            checkOutput("b_done", done_b, (i == 3));
            checkOutput("b_busy", busy_b, (i != 3));
            repeat (2) cycle();
            checkOutput("b_done_pulse", done_b, 0);
        end
    endtask

    initial begin
        int guard;
        rst_a = 1'b1; fv_a = 1'b0; tick_a = 1'b0;
        rst_b = 1'b1; fv_b = 1'b0; tick_b = 1'b0;
        repeat (3) cycle();
        checkOutput("rst_dac", dac_a, 12'h800);
        checkOutput("rst_busy", busy_a, 0);
        checkOutput("rst_done", done_a, 0);
        checkOutput("rst_urun", urun_a, 0);
        checkOutput("rst_addr", addr_a, 0);
        checkOutput("rst_b_dac", dac_b, 12'h800);
        rst_a = 1'b0;
        rst_b = 1'b0;

        for (int i = 0; i < 4; i++) begin
            tick_a = 1'b1;
            cycle();
            tick_a = 1'b0;
            checkOutput("idle_dac", dac_a, 12'h800);
            checkOutput("idle_busy", busy_a, 0);
            checkOutput("idle_urun", urun_a, 0);
            checkOutput("idle_addr", addr_a, 0);
        end

        // SHIFT=4 conversion table, then a frame_valid while busy
        applyStimulus(1'b0, 0);
        checkOutput("accept_busy", busy_a, 1);
        checkOutput("accept_addr", addr_a, 0);
        repeat (20) cycle();
        checkOutput("fill_addr", addr_a, 8);
        fv_a = 1'b1;
        cycle();
        fv_a = 1'b0;
        checkOutput("ignored_fv_addr", addr_a, 8);
        checkOutput("ignored_fv_busy", busy_a, 1);
        tickA("sat_pos_max");
        tickA("sat_neg_max");
        tickA("shift_plus_one");
        tickA("shift_minus_one");

        // Reset in the middle of the frame at address 100
        guard = 0;
        while (addr_a != 12'd100 && guard < 400) begin
            tickA("a_data");
            guard++;
        end
        checkOutput("reach_addr100", addr_a, 100);
        rst_a = 1'b1;
        cycle();
        rst_a = 1'b0;
        checkOutput("midrst_busy", busy_a, 0);
        checkOutput("midrst_dac", dac_a, 12'h800);
        checkOutput("midrst_done", done_a, 0);
        checkOutput("midrst_addr", addr_a, 0);
        sb_a.delete();
        for (int i = 0; i < 5; i++) begin
            cycle();
            checkOutput("midrst_no_done", done_a, 0);
            checkOutput("midrst_idle_busy", busy_a, 0);
        end

        // SHIFT=0 saturation, underrun on an early tick, sticky flag cleared by next frame
        applyStimulus(1'b1, 0);
        tick_b = 1'b1;
        cycle();
        tick_b = 1'b0;
        checkOutput("urun_set", urun_b, 1);
        checkOutput("urun_dac_held", dac_b, 12'h800);
        repeat (4) cycle();
        drainB();
        checkOutput("urun_sticky", urun_b, 1);
        tick_b = 1'b1;
        cycle();
        tick_b = 1'b0;
        checkOutput("b_dac_hold", dac_b, ref_sample(word_b(2'd3), 0));
        applyStimulus(1'b1, 0);
        checkOutput("urun_cleared", urun_b, 0);
        checkOutput("b2_busy", busy_b, 1);
        repeat (4) cycle();
        drainB();
        checkOutput("b2_urun", urun_b, 0);

        // Full 4096-point frame with address-as-data RAM
        last_addr = 0; addr_err = 0; max_occ = 0; pops_a = 0; done_pulses = 0;
        mon_a = 1'b1;
        applyStimulus(1'b0, 1);
        repeat (20) cycle();
        for (int i = 0; i < 4096; i++) begin
            tickA("full_data");
            checkOutput("full_done", done_a, (i == 4095));
            checkOutput("full_busy", busy_a, (i != 4095));
            if (i != 4095) repeat (TICK_GAP - 1) cycle();
        end
        cycle();
        checkOutput("full_done_width", done_a, 0);
        repeat (3) cycle();
        mon_a = 1'b0;
        checkOutput("full_addr_order", addr_err, 0);
        checkOutput("full_last_addr", last_addr, 4095);
        checkOutput("full_max_occupancy", max_occ, 8);
        checkOutput("full_done_pulses", done_pulses, 1);
        checkOutput("full_sb_left", sb_a.size(), 0);
        checkOutput("full_urun", urun_a, 0);
        tick_a = 1'b1;
        cycle();
        tick_a = 1'b0;
        checkOutput("post_frame_hold", dac_a, ref_sample(word_a(12'd4095, 1), 4));
        checkOutput("post_frame_urun", urun_a, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
